// File: rtl/pc_pkg.sv
// Shared defaults and next-PC select encoding for the fetch-stage PC sequencer.
package pc_pkg;

  localparam int PC_W_DEF      = 8;
  localparam int STEP_DEF      = 1;
  localparam int RESET_VEC_DEF = 0;
  localparam int STACK_D_DEF   = 4;

  // Winning request for the current cycle, chosen by the priority decoder.
  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_ADV  = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_BR   = 3'd3,
    SEL_CALL = 3'd4,
    SEL_RET  = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack. The parent never pushes when full or pops when
// empty, so the pointer needs no saturation logic here.
module pc_ret_stack #(
  parameter int PC_W    = 8,
  parameter int STACK_D = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_push_data,
  output logic [PC_W-1:0] o_top,
  output logic            o_full,
  output logic            o_empty
);

  localparam int SP_W  = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int MEM_N = 1 << IDX_W;

  logic [PC_W-1:0]  mem_q [MEM_N];
  logic [PC_W-1:0]  mem_d [MEM_N];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));

  // Pointer update and the full/empty flags derived from the next pointer.
  always_comb begin
    sp_d = sp_q;
    if (i_push) begin
      sp_d = sp_q + SP_W'(1);
    end else if (i_pop) begin
      sp_d = sp_q - SP_W'(1);
    end
    full_d  = (sp_d == SP_W'(STACK_D));
    empty_d = (sp_d == '0);
  end

  // Write the pushed return address into the slot at the current pointer.
  always_comb begin
    mem_d = mem_q;
    if (i_push) begin
      mem_d[wr_idx] = i_push_data;
    end
  end

  // Storage is deliberately not reset; only the pointer and flags are.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // Pointer and flag registers with synchronous reset to the empty state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign o_top   = mem_q[rd_idx];
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority decoder -> next-PC mux -> PC register,
// with a return-address stack for call/ret and sticky stack error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int RESET_VEC = RESET_VEC_DEF,
  parameter int STACK_D   = STACK_D_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_adv,
  input  logic            i_jump,
  input  logic            i_branch,
  input  logic            i_cond,
  input  logic [PC_W-1:0] i_offset,
  input  logic            i_call,
  input  logic            i_ret,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc,
  output logic            o_stk_full,
  output logic            o_stk_empty,
  output logic            o_ovf_err,
  output logic            o_udf_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  pc_sel_e         sel;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] stk_top;
  logic            stk_full;
  logic            stk_empty;
  logic            stk_push;
  logic            stk_pop;

  assign pc_seq = pc_q + PC_W'(STEP);

  // Pick the single highest-priority request; stall masks everything.
  always_comb begin
    sel = SEL_HOLD;
    if (i_stall) begin
      sel = SEL_HOLD;
    end else if (i_ret) begin
      sel = SEL_RET;
    end else if (i_call) begin
      sel = SEL_CALL;
    end else if (i_jump) begin
      sel = SEL_JMP;
    end else if (i_branch && i_cond) begin
      sel = SEL_BR;
    end else if (i_adv) begin
      sel = SEL_ADV;
    end
  end

  // Stack operations only fire when they can succeed.
  assign stk_push = (sel == SEL_CALL) && !stk_full;
  assign stk_pop  = (sel == SEL_RET) && !stk_empty;

  // Next PC and error flags; failed call/ret fall through to a plain advance.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    case (sel)
      SEL_ADV: pc_d = pc_seq;
      SEL_JMP: pc_d = i_target;
      SEL_BR:  pc_d = pc_q + i_offset;
      SEL_CALL: begin
        if (stk_full) begin
          pc_d  = pc_seq;
          ovf_d = 1'b1;
        end else begin
          pc_d = i_target;
        end
      end
      SEL_RET: begin
        if (stk_empty) begin
          pc_d  = pc_seq;
          udf_d = 1'b1;
        end else begin
          pc_d = stk_top;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // PC and sticky error registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q  <= PC_W'(RESET_VEC);
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  pc_ret_stack #(
    .PC_W    (PC_W),
    .STACK_D (STACK_D)
  ) u_ret_stack (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (stk_push),
    .i_pop       (stk_pop),
    .i_push_data (pc_seq),
    .o_top       (stk_top),
    .o_full      (stk_full),
    .o_empty     (stk_empty)
  );

  assign o_pc        = pc_q;
  assign o_stk_full  = stk_full;
  assign o_stk_empty = stk_empty;
  assign o_ovf_err   = ovf_q;
  assign o_udf_err   = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by random strobes,
// every cycle compared against a queue-based reference model.
module tb_pc_sequencer;

  localparam int PC_W      = 8;
  localparam int STEP      = 1;
  localparam int RESET_VEC = 0;
  localparam int STACK_D   = 4;

  typedef struct packed {
    logic       reset;
    logic       stall;
    logic       adv;
    logic       jump;
    logic       branch;
    logic       cond;
    logic [7:0] offset;
    logic       call;
    logic       ret;
    logic [7:0] target;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset, stall, adv, jump, branch, cond, call, ret;
  logic [7:0] offset, target;
  logic [7:0] pc;
  logic       stkFull, stkEmpty, ovfErr, udfErr;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] mPc;
  logic [7:0] mStack[$];
  logic       mOvf, mUdf;

  pc_sequencer #(
    .PC_W      (PC_W),
    .STEP      (STEP),
    .RESET_VEC (RESET_VEC),
    .STACK_D   (STACK_D)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_stall     (stall),
    .i_adv       (adv),
    .i_jump      (jump),
    .i_branch    (branch),
    .i_cond      (cond),
    .i_offset    (offset),
    .i_call      (call),
    .i_ret       (ret),
    .i_target    (target),
    .o_pc        (pc),
    .o_stk_full  (stkFull),
    .o_stk_empty (stkEmpty),
    .o_ovf_err   (ovfErr),
    .o_udf_err   (udfErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Architectural reference: apply one cycle of the priority rules.
  task automatic modelStep(input stim_t s);
    if (s.reset) begin
      mPc = 8'(RESET_VEC);
      mStack.delete();
      mOvf = 1'b0;
      mUdf = 1'b0;
    end else if (s.stall) begin
      // nothing changes
    end else if (s.ret) begin
      if (mStack.size() == 0) begin
        mPc  = mPc + 8'(STEP);
        mUdf = 1'b1;
      end else begin
        mPc = mStack.pop_back();
      end
    end else if (s.call) begin
      if (mStack.size() == STACK_D) begin
        mPc  = mPc + 8'(STEP);
        mOvf = 1'b1;
      end else begin
        mStack.push_back(mPc + 8'(STEP));
        mPc = s.target;
      end
    end else if (s.jump) begin
      mPc = s.target;
    end else if (s.branch && s.cond) begin
      mPc = mPc + s.offset;
    end else if (s.adv) begin
      mPc = mPc + 8'(STEP);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input string tag);
    reset  = s.reset;
    stall  = s.stall;
    adv    = s.adv;
    jump   = s.jump;
    branch = s.branch;
    cond   = s.cond;
    offset = s.offset;
    call   = s.call;
    ret    = s.ret;
    target = s.target;
    @(posedge clk);
    #1;
    modelStep(s);
    checkOutput({tag, ".pc"},    32'(pc),       32'(mPc));
    checkOutput({tag, ".full"},  32'(stkFull),  32'(mStack.size() == STACK_D));
    checkOutput({tag, ".empty"}, 32'(stkEmpty), 32'(mStack.size() == 0));
    checkOutput({tag, ".ovf"},   32'(ovfErr),   32'(mOvf));
    checkOutput({tag, ".udf"},   32'(udfErr),   32'(mUdf));
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic doReset(input string tag);
    stim_t s = idle();
    s.reset = 1'b1;
    applyStimulus(s, tag);
  endtask

  task automatic doAdv(input string tag);
    stim_t s = idle();
    s.adv = 1'b1;
    applyStimulus(s, tag);
  endtask

  task automatic doJump(input logic [7:0] t, input string tag);
    stim_t s = idle();
    s.jump   = 1'b1;
    s.target = t;
    applyStimulus(s, tag);
  endtask

  task automatic doCall(input logic [7:0] t, input string tag);
    stim_t s = idle();
    s.call   = 1'b1;
    s.target = t;
    applyStimulus(s, tag);
  endtask

  task automatic doRet(input string tag);
    stim_t s = idle();
    s.ret = 1'b1;
    applyStimulus(s, tag);
  endtask

  task automatic doBranch(input logic c, input logic a, input logic [7:0] off, input string tag);
    stim_t s = idle();
    s.branch = 1'b1;
    s.cond   = c;
    s.adv    = a;
    s.offset = off;
    applyStimulus(s, tag);
  endtask

  initial begin
    stim_t s;
    logic [7:0] callTargets [4];
    callTargets[0] = 8'h10;
    callTargets[1] = 8'h20;
    callTargets[2] = 8'h30;
    callTargets[3] = 8'h40;
    mPc  = '0;
    mOvf = 1'b0;
    mUdf = 1'b0;
    {reset, stall, adv, jump, branch, cond, call, ret} = '0;
    offset = '0;
    target = '0;

    // Reset then sequential advance; reset mid-run.
    doReset("reset");
    checkOutput("reset.pc_const", 32'(pc), 32'h00);
    for (int i = 0; i < 3; i++) doAdv("adv");
    checkOutput("adv3.pc_const", 32'(pc), 32'h03);
    doReset("reset_mid");

    // Wrap on advance and negative branch.
    doJump(8'hFE, "jump_fe");
    doAdv("wrap_ff");
    doAdv("wrap_00");
    checkOutput("wrap.pc_const", 32'(pc), 32'h00);
    doJump(8'h02, "jump_02");
    doBranch(1'b1, 1'b0, 8'hFC, "br_neg");
    checkOutput("br_neg.pc_const", 32'(pc), 32'hFE);

    // Single call/ret round trip.
    doJump(8'h05, "jump_05");
    doCall(8'h40, "call_40");
    doRet("ret_06");
    checkOutput("ret.pc_const", 32'(pc), 32'h06);

    // Fill the stack, overflow, unwind, underflow.
    for (int i = 0; i < 4; i++) doCall(callTargets[i], "call_fill");
    checkOutput("fill.full_const", 32'(stkFull), 32'h1);
    doCall(8'h77, "call_ovf");
    checkOutput("ovf.pc_const", 32'(pc), 32'h41);
    for (int i = 0; i < 4; i++) doRet("ret_unwind");
    checkOutput("unwind.pc_const", 32'(pc), 32'h07);
    doRet("ret_udf");
    checkOutput("udf.flag_const", 32'(udfErr), 32'h1);

    // Coincident strobes and stall.
    doReset("reset2");
    s = idle();
    s.jump = 1'b1; s.target = 8'h80; s.branch = 1'b1; s.cond = 1'b1;
    s.offset = 8'h10; s.adv = 1'b1;
    applyStimulus(s, "prio_jump");
    s = idle();
    s.stall = 1'b1; s.call = 1'b1; s.target = 8'h33;
    applyStimulus(s, "stall_call");
    s = idle();
    s.stall = 1'b1; s.reset = 1'b1; s.adv = 1'b1;
    applyStimulus(s, "stall_reset");

    // Branch not taken, with and without advance.
    doJump(8'h20, "jump_20");
    doBranch(1'b0, 1'b0, 8'h05, "br_hold");
    doBranch(1'b0, 1'b1, 8'h05, "br_adv");

    // Random strobes against the model.
    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.reset  = ($urandom_range(0, 99) < 2);
      s.stall  = ($urandom_range(0, 99) < 10);
      s.ret    = ($urandom_range(0, 99) < 15);
      s.call   = ($urandom_range(0, 99) < 18);
      s.jump   = ($urandom_range(0, 99) < 10);
      s.branch = ($urandom_range(0, 99) < 30);
      s.cond   = ($urandom_range(0, 99) < 50);
      s.adv    = ($urandom_range(0, 99) < 60);
      s.offset = 8'($urandom);
      s.target = 8'($urandom);
      applyStimulus(s, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
